// File: rtl/multicycle_control.sv
// ============================================================================
// Module   : multicycle_control
// Brief    : Multi-cycle MIPS-subset control FSM driving the DataPath enables,
//            mux selects and a retired-instruction counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_control #(
    parameter int RETIRE_W = 16
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [5:0]          opcode,
    input  logic [5:0]          funct,
    input  logic                zero,
    input  logic                memReady,
    output logic                memReadEnable,
    output logic                memWriteEnable,
    output logic                iOrD,
    output logic                irWriteEnable,
    output logic                pcWriteEnable,
    output logic                regWriteEnable,
    output logic                regDst,
    output logic                memToReg,
    output logic                aluSrcA,
    output logic [1:0]          aluSrcB,
    output logic [2:0]          aluControl,
    output logic [1:0]          pcSrc,
    output logic [3:0]          state,
    output logic                halted,
    output logic [RETIRE_W-1:0] retired
);

    localparam logic [3:0] c_FETCH    = 4'd0;
    localparam logic [3:0] c_DECODE   = 4'd1;
    localparam logic [3:0] c_MEMADR   = 4'd2;
    localparam logic [3:0] c_MEMREAD  = 4'd3;
    localparam logic [3:0] c_MEMWB    = 4'd4;
    localparam logic [3:0] c_MEMWRITE = 4'd5;
    localparam logic [3:0] c_EXECUTE  = 4'd6;
    localparam logic [3:0] c_ALUWB    = 4'd7;
    localparam logic [3:0] c_BRANCH   = 4'd8;
    localparam logic [3:0] c_ADDIEX   = 4'd9;
    localparam logic [3:0] c_ADDIWB   = 4'd10;
    localparam logic [3:0] c_JUMP     = 4'd11;
    localparam logic [3:0] c_HALT     = 4'd15;

    localparam logic [5:0] c_OP_RTYPE = 6'b000000;
    localparam logic [5:0] c_OP_LW    = 6'b100011;
    localparam logic [5:0] c_OP_SW    = 6'b101011;
    localparam logic [5:0] c_OP_BEQ   = 6'b000100;
    localparam logic [5:0] c_OP_ADDI  = 6'b001000;
    localparam logic [5:0] c_OP_J     = 6'b000010;

    localparam logic [2:0] c_ALU_ADD = 3'b010;
    localparam logic [2:0] c_ALU_SUB = 3'b110;
    localparam logic [2:0] c_ALU_AND = 3'b000;
    localparam logic [2:0] c_ALU_OR  = 3'b001;
    localparam logic [2:0] c_ALU_SLT = 3'b111;

    localparam logic [RETIRE_W-1:0] c_ONE = {{(RETIRE_W-1){1'b0}}, 1'b1};

    logic [3:0]          r_state;
    logic [3:0]          w_next;
    logic [RETIRE_W-1:0] r_retired;
    logic                w_retire;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= c_FETCH;
            r_retired <= '0;
        end else begin
            r_state <= w_next;
            if (w_retire) begin
                r_retired <= r_retired + c_ONE;
            end
        end
    end

    always_comb begin
        w_next         = r_state;
        w_retire       = 1'b0;
        memReadEnable  = 1'b0;
        memWriteEnable = 1'b0;
        iOrD           = 1'b0;
        irWriteEnable  = 1'b0;
        pcWriteEnable  = 1'b0;
        regWriteEnable = 1'b0;
        regDst         = 1'b0;
        memToReg       = 1'b0;
        aluSrcA        = 1'b0;
        aluSrcB        = 2'b00;
        aluControl     = 3'b000;
        pcSrc          = 2'b00;
        halted         = 1'b0;

        case (r_state)
            c_FETCH: begin
                memReadEnable = 1'b1;
                aluSrcB       = 2'b01;
                aluControl    = c_ALU_ADD;
                // IR and PC load only when the fetch read actually completes
                if (memReady) begin
                    irWriteEnable = 1'b1;
                    pcWriteEnable = 1'b1;
                    w_next        = c_DECODE;
                end
            end
            c_DECODE: begin
                aluSrcB    = 2'b11;
                aluControl = c_ALU_ADD;
                case (opcode)
                    c_OP_LW, c_OP_SW: w_next = c_MEMADR;
                    c_OP_RTYPE:       w_next = c_EXECUTE;
                    c_OP_BEQ:         w_next = c_BRANCH;
                    c_OP_ADDI:        w_next = c_ADDIEX;
                    c_OP_J:           w_next = c_JUMP;
                    default:          w_next = c_HALT;
                endcase
            end
            c_MEMADR: begin
                aluSrcA    = 1'b1;
                aluSrcB    = 2'b10;
                aluControl = c_ALU_ADD;
                w_next     = (opcode == c_OP_SW) ? c_MEMWRITE : c_MEMREAD;
            end
            c_MEMREAD: begin
                memReadEnable = 1'b1;
                iOrD          = 1'b1;
                if (memReady) begin
                    w_next = c_MEMWB;
                end
            end
            c_MEMWB: begin
                regWriteEnable = 1'b1;
                memToReg       = 1'b1;
                w_next         = c_FETCH;
                w_retire       = 1'b1;
            end
            c_MEMWRITE: begin
                memWriteEnable = 1'b1;
                iOrD           = 1'b1;
                if (memReady) begin
                    w_next   = c_FETCH;
                    w_retire = 1'b1;
                end
            end
            c_EXECUTE: begin
                aluSrcA = 1'b1;
                w_next  = c_ALUWB;
                case (funct)
                    6'b100000: aluControl = c_ALU_ADD;
                    6'b100010: aluControl = c_ALU_SUB;
                    6'b100100: aluControl = c_ALU_AND;
                    6'b100101: aluControl = c_ALU_OR;
                    6'b101010: aluControl = c_ALU_SLT;
                    default:   w_next     = c_HALT;
                endcase
            end
            c_ALUWB: begin
                regWriteEnable = 1'b1;
                regDst         = 1'b1;
                w_next         = c_FETCH;
                w_retire       = 1'b1;
            end
            c_BRANCH: begin
                aluSrcA       = 1'b1;
                aluControl    = c_ALU_SUB;
                pcSrc         = 2'b01;
                pcWriteEnable = zero;
                w_next        = c_FETCH;
                w_retire      = 1'b1;
            end
            c_ADDIEX: begin
                aluSrcA    = 1'b1;
                aluSrcB    = 2'b10;
                aluControl = c_ALU_ADD;
                w_next     = c_ADDIWB;
            end
            c_ADDIWB: begin
                regWriteEnable = 1'b1;
                w_next         = c_FETCH;
                w_retire       = 1'b1;
            end
            c_JUMP: begin
                pcSrc         = 2'b10;
                pcWriteEnable = 1'b1;
                w_next        = c_FETCH;
                w_retire      = 1'b1;
            end
            c_HALT: begin
                halted = 1'b1;
                w_next = c_HALT;
            end
            default: begin
                w_next = c_HALT;
            end
        endcase
    end

    assign state   = r_state;
    assign retired = r_retired;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_control.sv
// ============================================================================
// Module   : tb_multicycle_control
// Brief    : Vector table plus scoreboard bench for multicycle_control.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multicycle_control;

    // {memRd, memWr, iOrD, irWr, pcWr, regWr, regDst, memToReg, srcA, srcB, aluCtl, pcSrc, halted}
    localparam logic [16:0] c_F_WAIT = 17'b1_0_0_0_0_0_0_0_0_01_010_00_0;
    localparam logic [16:0] c_F_GO   = 17'b1_0_0_1_1_0_0_0_0_01_010_00_0;
    localparam logic [16:0] c_DEC    = 17'b0_0_0_0_0_0_0_0_0_11_010_00_0;
    localparam logic [16:0] c_MADR   = 17'b0_0_0_0_0_0_0_0_1_10_010_00_0;
    localparam logic [16:0] c_MRD    = 17'b1_0_1_0_0_0_0_0_0_00_000_00_0;
    localparam logic [16:0] c_MWB    = 17'b0_0_0_0_0_1_0_1_0_00_000_00_0;
    localparam logic [16:0] c_MWR    = 17'b0_1_1_0_0_0_0_0_0_00_000_00_0;
    localparam logic [16:0] c_E_ADD  = 17'b0_0_0_0_0_0_0_0_1_00_010_00_0;
    localparam logic [16:0] c_E_SUB  = 17'b0_0_0_0_0_0_0_0_1_00_110_00_0;
    localparam logic [16:0] c_E_AND  = 17'b0_0_0_0_0_0_0_0_1_00_000_00_0;
    localparam logic [16:0] c_E_OR   = 17'b0_0_0_0_0_0_0_0_1_00_001_00_0;
    localparam logic [16:0] c_E_SLT  = 17'b0_0_0_0_0_0_0_0_1_00_111_00_0;
    localparam logic [16:0] c_AWB    = 17'b0_0_0_0_0_1_1_0_0_00_000_00_0;
    localparam logic [16:0] c_BR_T   = 17'b0_0_0_0_1_0_0_0_1_00_110_01_0;
    localparam logic [16:0] c_BR_N   = 17'b0_0_0_0_0_0_0_0_1_00_110_01_0;
    localparam logic [16:0] c_IWB    = 17'b0_0_0_0_0_1_0_0_0_00_000_00_0;
    localparam logic [16:0] c_JMP    = 17'b0_0_0_0_1_0_0_0_0_00_000_10_0;
    localparam logic [16:0] c_HLT    = 17'b0_0_0_0_0_0_0_0_0_00_000_00_1;

    localparam logic [5:0] c_R = 6'b000000, c_LW = 6'b100011, c_SW = 6'b101011;
    localparam logic [5:0] c_BEQ = 6'b000100, c_ADDI = 6'b001000, c_J = 6'b000010;
    localparam logic [5:0] c_BAD = 6'b111111;

    typedef struct {
        logic        rst;
        logic        mr;
        logic [5:0]  op;
        logic [5:0]  fn;
        logic        z;
        logic [3:0]  expState;
        logic [16:0] expCtl;
        logic        chkCtl;
        logic [15:0] expRet;
    } vec_t;

    logic clk = 1'b0;
    logic rst, mr, z;
    logic [5:0] op, fn;
    logic memRd, memWr, iOrD, irWr, pcWr, regWr, regDst, memToReg, srcA, halted;
    logic [1:0] srcB, pcSrc;
    logic [2:0] aluCtl;
    logic [3:0] st;
    logic [15:0] ret;
    logic memRd4, memWr4, iOrD4, irWr4, pcWr4, regWr4, regDst4, memToReg4, srcA4, halted4;
    logic [1:0] srcB4, pcSrc4;
    logic [2:0] aluCtl4;
    logic [3:0] st4;
    logic [3:0] ret4;

    int passed = 0;
    int total  = 0;
    vec_t tbl[$];
    vec_t sb[$];
    logic [15:0] r;

    always #5 clk = ~clk;

    multicycle_control dut (
        .clock(clk), .reset(rst), .opcode(op), .funct(fn), .zero(z), .memReady(mr),
        .memReadEnable(memRd), .memWriteEnable(memWr), .iOrD(iOrD), .irWriteEnable(irWr),
        .pcWriteEnable(pcWr), .regWriteEnable(regWr), .regDst(regDst), .memToReg(memToReg),
        .aluSrcA(srcA), .aluSrcB(srcB), .aluControl(aluCtl), .pcSrc(pcSrc),
        .state(st), .halted(halted), .retired(ret)
    );

    multicycle_control #(.RETIRE_W(4)) dut4 (
        .clock(clk), .reset(rst), .opcode(op), .funct(fn), .zero(z), .memReady(mr),
        .memReadEnable(memRd4), .memWriteEnable(memWr4), .iOrD(iOrD4), .irWriteEnable(irWr4),
        .pcWriteEnable(pcWr4), .regWriteEnable(regWr4), .regDst(regDst4), .memToReg(memToReg4),
        .aluSrcA(srcA4), .aluSrcB(srcB4), .aluControl(aluCtl4), .pcSrc(pcSrc4),
        .state(st4), .halted(halted4), .retired(ret4)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // Checker pops one expected record per cycle, mid-low-phase.
    always @(negedge clk) begin
        #2;
        if (sb.size() > 0) begin
            vec_t e;
            logic [16:0] ctl;
            e = sb.pop_front();
            ctl = {memRd, memWr, iOrD, irWr, pcWr, regWr, regDst, memToReg,
                   srcA, srcB, aluCtl, pcSrc, halted};
            check("state", {28'd0, st}, {28'd0, e.expState});
            if (e.chkCtl) check("ctl", {15'd0, ctl}, {15'd0, e.expCtl});
            check("retired", {16'd0, ret}, {16'd0, e.expRet});
            check("retired4", {28'd0, ret4}, {28'd0, e.expRet[3:0]});
        end
    end

    task automatic step(input vec_t v);
        @(negedge clk);
        rst = v.rst; mr = v.mr; op = v.op; fn = v.fn; z = v.z;
        sb.push_back(v);
    endtask

    task automatic add(input logic rs, input logic m, input logic [5:0] o, input logic [5:0] f,
                       input logic zz, input logic [3:0] s, input logic [16:0] c,
                       input logic k, input logic [15:0] rt);
        vec_t v;
        v.rst = rs; v.mr = m; v.op = o; v.fn = f; v.z = zz;
        v.expState = s; v.expCtl = c; v.chkCtl = k; v.expRet = rt;
        tbl.push_back(v);
    endtask

    task automatic go(input logic rs, input logic m, input logic [5:0] o, input logic [5:0] f,
                      input logic zz, input logic [3:0] s, input logic [16:0] c,
                      input logic k, input logic [15:0] rt);
        vec_t v;
        v.rst = rs; v.mr = m; v.op = o; v.fn = f; v.z = zz;
        v.expState = s; v.expCtl = c; v.chkCtl = k; v.expRet = rt;
        step(v);
    endtask

    task automatic rtype(input logic [5:0] f, input logic [16:0] ex, input logic [15:0] rt);
        add(0, 1, c_R, f, 0, 0, c_F_GO, 1, rt);
        add(0, 1, c_R, f, 0, 1, c_DEC, 1, rt);
        add(0, 1, c_R, f, 0, 6, ex, 1, rt);
        add(0, 1, c_R, f, 0, 7, c_AWB, 1, rt);
    endtask

    initial begin
        rst = 1'b1; mr = 1'b0; op = '0; fn = '0; z = 1'b0;

        rtype(6'b100000, c_E_ADD, 0);
        rtype(6'b100010, c_E_SUB, 1);
        add(0, 1, c_LW, 0, 0, 0, c_F_GO, 1, 2);
        add(0, 1, c_LW, 0, 0, 1, c_DEC,  1, 2);
        add(0, 1, c_LW, 0, 0, 2, c_MADR, 1, 2);
        add(0, 0, c_LW, 0, 0, 3, c_MRD,  1, 2);
        add(0, 0, c_LW, 0, 0, 3, c_MRD,  1, 2);
        add(0, 1, c_LW, 0, 0, 3, c_MRD,  1, 2);
        add(0, 1, c_LW, 0, 0, 4, c_MWB,  1, 2);
        add(0, 0, c_SW, 0, 0, 0, c_F_WAIT, 1, 3);
        add(0, 1, c_SW, 0, 0, 0, c_F_GO, 1, 3);
        add(0, 1, c_SW, 0, 0, 1, c_DEC,  1, 3);
        add(0, 1, c_SW, 0, 0, 2, c_MADR, 1, 3);
        add(0, 0, c_SW, 0, 0, 5, c_MWR,  1, 3);
        add(0, 1, c_SW, 0, 0, 5, c_MWR,  1, 3);
        add(0, 1, c_ADDI, 0, 0, 0,  c_F_GO, 1, 4);
        add(0, 1, c_ADDI, 0, 0, 1,  c_DEC,  1, 4);
        add(0, 1, c_ADDI, 0, 0, 9,  c_MADR, 1, 4);
        add(0, 1, c_ADDI, 0, 0, 10, c_IWB,  1, 4);
        add(0, 1, c_BEQ, 0, 1, 0, c_F_GO, 1, 5);
        add(0, 1, c_BEQ, 0, 1, 1, c_DEC,  1, 5);
        add(0, 1, c_BEQ, 0, 1, 8, c_BR_T, 1, 5);
        add(0, 1, c_BEQ, 0, 0, 0, c_F_GO, 1, 6);
        add(0, 1, c_BEQ, 0, 0, 1, c_DEC,  1, 6);
        add(0, 1, c_BEQ, 0, 0, 8, c_BR_N, 1, 6);
        rtype(6'b100100, c_E_AND, 7);
        rtype(6'b100101, c_E_OR,  8);
        rtype(6'b101010, c_E_SLT, 9);

        repeat (2) @(posedge clk);
        for (int i = 0; i < tbl.size(); i++) step(tbl[i]);

        // Illegal opcode: parks in HALT until reset
        go(0, 1, c_BAD, 0, 0, 0, c_F_GO, 1, 10);
        go(0, 1, c_BAD, 0, 0, 1, c_DEC,  1, 10);
        for (int i = 0; i < 12; i++) begin
            go(0, 1'($urandom_range(0, 1)), 6'($urandom), 6'($urandom), 1'($urandom_range(0, 1)),
               15, c_HLT, 1, 10);
        end
        go(1, 0, c_J, 0, 0, 15, c_HLT, 1, 10);
        go(0, 0, c_J, 0, 0, 0, c_F_WAIT, 1, 0);

        // Reset while a store is waiting on memory
        go(0, 1, c_J,  0, 0, 0,  c_F_GO, 1, 0);
        go(0, 1, c_J,  0, 0, 1,  c_DEC,  1, 0);
        go(0, 1, c_J,  0, 0, 11, c_JMP,  1, 0);
        go(0, 1, c_SW, 0, 0, 0,  c_F_GO, 1, 1);
        go(0, 1, c_SW, 0, 0, 1,  c_DEC,  1, 1);
        go(0, 1, c_SW, 0, 0, 2,  c_MADR, 1, 1);
        go(0, 0, c_SW, 0, 0, 5,  c_MWR,  1, 1);
        go(1, 0, c_SW, 0, 0, 5,  c_MWR,  1, 1);
        go(0, 0, c_SW, 0, 0, 0,  c_F_WAIT, 1, 0);

        // Unknown funct: HALT without writeback
        go(0, 1, c_R, c_BAD, 0, 0,  c_F_GO, 1, 0);
        go(0, 1, c_R, c_BAD, 0, 1,  c_DEC,  1, 0);
        go(0, 1, c_R, c_BAD, 0, 6,  c_HLT,  0, 0);
        go(0, 1, c_R, c_BAD, 0, 15, c_HLT,  1, 0);
        go(1, 1, c_R, c_BAD, 0, 15, c_HLT,  1, 0);

        // Sixteen jumps: the 4-bit counter wraps back to zero
        for (int i = 0; i < 16; i++) begin
            r = 16'(i);
            go(0, 1, c_J, 0, 0, 0,  c_F_GO, 1, r);
            go(0, 1, c_J, 0, 0, 1,  c_DEC,  1, r);
            go(0, 1, c_J, 0, 0, 11, c_JMP,  1, r);
        end
        go(0, 0, c_J, 0, 0, 0, c_F_WAIT, 1, 16);

        @(negedge clk);
        #4;
        if (sb.size() != 0) begin
            total++;
            $display("FAIL scoreboard: %0d entries left, expected 0", sb.size());
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

`default_nettype wire
